// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - step sequencer feeding the note LUT and tone divider
module note_sequencer #(
    parameter int STEPS   = 16,
    parameter int ADDR_W  = 4,
    parameter int TEMPO_W = 20,
    parameter int LUT_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [8:0]         wr_data,
    input  logic [TEMPO_W-1:0] tempo,
    input  logic               loop_en,
    input  logic               start,
    input  logic               stop,
    output logic [3:0]         lut_note,
    output logic [3:0]         lut_octave,
    input  logic [15:0]        lut_div,
    output logic [15:0]        tone_div,
    output logic               tone_load,
    output logic               gate,
    output logic               busy,
    output logic [ADDR_W-1:0]  step_idx
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOOKUP = 3'd2,
        LOAD   = 3'd3,
        HOLD   = 3'd4
    } state_t;

    localparam logic [TEMPO_W-1:0] LOOKUP_LAST = TEMPO_W'(LUT_LAT - 1);
    localparam logic [ADDR_W-1:0]  LAST_IDX    = ADDR_W'(STEPS - 1);

    logic [8:0] mem_q [STEPS];
    logic [8:0] rd_word;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  step_idx_q, step_idx_d;
    logic [3:0]         lut_note_q, lut_note_d;
    logic [3:0]         lut_octave_q, lut_octave_d;
    logic [15:0]        tone_div_q, tone_div_d;
    logic               tone_load_q, tone_load_d;
    logic               gate_q, gate_d;
    logic               busy_q, busy_d;
    logic               last_q, last_d;
    logic               rest_q, rest_d;
    logic [TEMPO_W-1:0] cnt_q, cnt_d;

    // Pattern storage: written from the host in any state, never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_word = mem_q[step_idx_q];

    // Next-state and next-output computation for the sequencer FSM
    always_comb begin
        state_d      = state_q;
        step_idx_d   = step_idx_q;
        lut_note_d   = lut_note_q;
        lut_octave_d = lut_octave_q;
        tone_div_d   = tone_div_q;
        tone_load_d  = 1'b0;
        gate_d       = gate_q;
        last_d       = last_q;
        rest_d       = rest_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d    = FETCH;
                    step_idx_d = '0;
                end
            end
            FETCH: begin
                lut_note_d   = rd_word[7:4];
                lut_octave_d = rd_word[3:0];
                last_d       = rd_word[8];
                rest_d       = (rd_word[7:4] >= 4'd12);
                cnt_d        = '0;
                state_d      = LOOKUP;
            end
            LOOKUP: begin
                if (cnt_q == LOOKUP_LAST) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + TEMPO_W'(1);
                end
            end
            LOAD: begin
                if (rest_q) begin
                    gate_d = 1'b0;
                end else begin
                    tone_div_d  = lut_div;
                    tone_load_d = 1'b1;
                    gate_d      = 1'b1;
                end
                cnt_d   = (tempo == '0) ? TEMPO_W'(1) : tempo;
                state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q <= TEMPO_W'(1)) begin
                    if (last_q || (step_idx_q == LAST_IDX)) begin
                        if (loop_en) begin
                            step_idx_d = '0;
                            state_d    = FETCH;
                        end else begin
                            gate_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        step_idx_d = step_idx_q + ADDR_W'(1);
                        state_d    = FETCH;
                    end
                end else begin
                    cnt_d = cnt_q - TEMPO_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gate_d  = 1'b0;
            end
        endcase

        // A stop request overrides whatever the active state decided
        if (stop && (state_q != IDLE)) begin
            state_d     = IDLE;
            gate_d      = 1'b0;
            tone_load_d = 1'b0;
            step_idx_d  = '0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            step_idx_q   <= '0;
            lut_note_q   <= '0;
            lut_octave_q <= '0;
            tone_div_q   <= '0;
            tone_load_q  <= 1'b0;
            gate_q       <= 1'b0;
            busy_q       <= 1'b0;
            last_q       <= 1'b0;
            rest_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            step_idx_q   <= step_idx_d;
            lut_note_q   <= lut_note_d;
            lut_octave_q <= lut_octave_d;
            tone_div_q   <= tone_div_d;
            tone_load_q  <= tone_load_d;
            gate_q       <= gate_d;
            busy_q       <= busy_d;
            last_q       <= last_d;
            rest_q       <= rest_d;
            cnt_q        <= cnt_d;
        end
    end

    assign lut_note   = lut_note_q;
    assign lut_octave = lut_octave_q;
    assign tone_div   = tone_div_q;
    assign tone_load  = tone_load_q;
    assign gate       = gate_q;
    assign busy       = busy_q;
    assign step_idx   = step_idx_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed bench for note_sequencer
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [8:0]  wr_data = '0;
    logic [19:0] tempo = '0;
    logic        loop_en = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  lut_note;
    logic [3:0]  lut_octave;
    logic [15:0] lut_div;
    logic [15:0] tone_div;
    logic        tone_load;
    logic        gate;
    logic        busy;
    logic [3:0]  step_idx;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;

    localparam logic [15:0] BASE [12] = '{16'd30581, 16'd28865, 16'd27245, 16'd25715,
                                          16'd24272, 16'd22910, 16'd21622, 16'd20408,
                                          16'd19263, 16'd18183, 16'd17161, 16'd16199};

    logic [15:0] lut_s1, lut_s2;

    note_sequencer dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .tempo(tempo), .loop_en(loop_en), .start(start), .stop(stop),
        .lut_note(lut_note), .lut_octave(lut_octave), .lut_div(lut_div),
        .tone_div(tone_div), .tone_load(tone_load), .gate(gate), .busy(busy),
        .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lut_f(input logic [3:0] n, input logic [3:0] o);
        if (n >= 4'd12) return 16'd0;
        return BASE[n] >> o;
    endfunction

    // Two-cycle registered LUT stand-in
    always @(posedge clk) begin
        lut_s1 <= lut_f(lut_note, lut_octave);
        lut_s2 <= lut_s1;
    end
    assign lut_div = lut_s2;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic at(input int e);
        while (cyc - t0 < e) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [8:0] d);
        wr_en = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    initial begin
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_gate", 32'(gate), 0);
        check("rst_tone_div", 32'(tone_div), 0);
        check("rst_tone_load", 32'(tone_load), 0);
        check("rst_step_idx", 32'(step_idx), 0);
        check("rst_lut_note", 32'(lut_note), 0);
        tick();
        rst = 1'b0;
        tick();

        // Single last step, tempo 5, no loop
        wr(0, 9'h194);
        tempo = 20'd5;
        loop_en = 1'b0;
        go();
        check("t1_busy_fetch", 32'(busy), 1);
        at(1);
        check("t1_lut_note", 32'(lut_note), 9);
        check("t1_lut_oct", 32'(lut_octave), 4);
        at(3);
        check("t1_no_load_early", 32'(tone_load), 0);
        at(4);
        check("t1_tone_load", 32'(tone_load), 1);
        check("t1_tone_div", 32'(tone_div), 1136);
        check("t1_gate", 32'(gate), 1);
        at(5);
        check("t1_load_pulse", 32'(tone_load), 0);
        at(8);
        check("t1_busy_hold", 32'(busy), 1);
        at(9);
        check("t1_idle", 32'(busy), 0);
        check("t1_gate_off", 32'(gate), 0);

        // Three steps with a rest, looping, tempo 3
        wr(0, 9'h000);
        wr(1, 9'h0F0);
        wr(2, 9'h1B8);
        tempo = 20'd3;
        loop_en = 1'b1;
        go();
        at(4);
        check("t2_s0_load", 32'(tone_load), 1);
        check("t2_s0_div", 32'(tone_div), 30581);
        at(11);
        check("t2_rest_noload", 32'(tone_load), 0);
        check("t2_rest_gate", 32'(gate), 0);
        check("t2_rest_div", 32'(tone_div), 30581);
        check("t2_rest_idx", 32'(step_idx), 1);
        at(18);
        check("t2_s2_load", 32'(tone_load), 1);
        check("t2_s2_div", 32'(tone_div), 63);
        check("t2_s2_idx", 32'(step_idx), 2);
        at(21);
        check("t2_wrap_idx", 32'(step_idx), 0);
        check("t2_wrap_gate", 32'(gate), 1);
        at(25);
        check("t2_wrap_load", 32'(tone_load), 1);
        check("t2_wrap_div", 32'(tone_div), 30581);
        // stop with start during LOOKUP of step 2 on the second pass
        at(36);
        check("t2_idx_before_stop", 32'(step_idx), 2);
        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        check("t2_stop_busy", 32'(busy), 0);
        check("t2_stop_gate", 32'(gate), 0);
        check("t2_stop_load", 32'(tone_load), 0);
        check("t2_stop_idx", 32'(step_idx), 0);
        check("t2_stop_div", 32'(tone_div), 30581);
        tick();
        tick();
        check("t2_stays_idle", 32'(busy), 0);
        check("t2_no_late_load", 32'(tone_load), 0);

        // tempo 0 -> five-cycle period
        wr(0, 9'h194);
        tempo = 20'd0;
        loop_en = 1'b1;
        go();
        at(4);
        check("t3_load0", 32'(tone_load), 1);
        at(5);
        check("t3_refetch_busy", 32'(busy), 1);
        check("t3_load_gap", 32'(tone_load), 0);
        at(8);
        check("t3_no_load_early", 32'(tone_load), 0);
        at(9);
        check("t3_load1", 32'(tone_load), 1);
        halt();

        // Reset during HOLD
        tempo = 20'd5;
        loop_en = 1'b0;
        go();
        at(6);
        check("t4_in_hold", 32'(gate), 1);
        rst = 1'b1;
        #1;
        check("t4_rst_busy", 32'(busy), 0);
        check("t4_rst_gate", 32'(gate), 0);
        check("t4_rst_div", 32'(tone_div), 0);
        check("t4_rst_note", 32'(lut_note), 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("t4_quiet_busy", 32'(busy), 0);
        check("t4_quiet_load", 32'(tone_load), 0);

        // Sixteen steps, no last flag, no loop, tempo 2 -> period 6
        for (int i = 0; i < 16; i++) wr(i, {1'b0, 4'(i % 12), 4'd1});
        tempo = 20'd2;
        loop_en = 1'b0;
        go();
        for (int k = 0; k < 16; k++) begin
            at(6 * k + 4);
            check($sformatf("t5_load_%0d", k), 32'(tone_load), 1);
            check($sformatf("t5_div_%0d", k), 32'(tone_div), 32'(lut_f(4'(k % 12), 4'd1)));
            check($sformatf("t5_idx_%0d", k), 32'(step_idx), 32'(k));
            if (k == 3) begin
                wr(3, 9'h000);
                check("t5_write_during_hold", 32'(tone_div), 32'(lut_f(4'd3, 4'd1)));
            end
        end
        at(95);
        check("t5_busy_end", 32'(busy), 1);
        at(96);
        check("t5_idle_end", 32'(busy), 0);
        check("t5_gate_end", 32'(gate), 0);
        go();
        at(22);
        check("t5_new_value", 32'(tone_div), 30581);
        halt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
